// File: rtl/gtxe2_chnl_cpll_refsel_ctrl.sv
// CPLL reference-clock select sequencer: powers the CPLL down, swaps the
// reference mux while powered down, pulses reset, then waits for lock.
module gtxe2_chnl_cpll_refsel_ctrl #(
    parameter logic [2:0] INIT_SEL     = 3'b001,
    parameter int         PD_CYCLES    = 16,
    parameter int         RST_CYCLES   = 8,
    parameter int         LOCK_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_req,
    input  logic [2:0] sel_new,
    input  logic       CPLLLOCK,
    output logic [2:0] CPLLREFCLKSEL,
    output logic       CPLLPD,
    output logic       CPLLRESET,
    output logic       sel_busy,
    output logic       sel_done,
    output logic       sel_err,
    output logic       cpll_ready
);

    localparam int MAX_PR  = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
    localparam int MAX_CNT = (MAX_PR > LOCK_TIMEOUT) ? MAX_PR : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PD_LAST  = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        PD,
        RST,
        LOCK
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic [2:0]    sel_cap, sel_cap_next;
    logic [2:0]    sel_next;
    logic          locked, locked_next;
    logic          done_next, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PD;
            count         <= '0;
            sel_cap       <= INIT_SEL;
            CPLLREFCLKSEL <= INIT_SEL;
            CPLLPD        <= 1'b1;
            CPLLRESET     <= 1'b0;
            sel_busy      <= 1'b1;
            sel_done      <= 1'b0;
            sel_err       <= 1'b0;
            cpll_ready    <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            sel_cap       <= sel_cap_next;
            CPLLREFCLKSEL <= sel_next;
            CPLLPD        <= (state_next == PD);
            CPLLRESET     <= (state_next == RST);
            sel_busy      <= (state_next != IDLE);
            sel_done      <= done_next;
            sel_err       <= err_next;
            cpll_ready    <= (state_next == IDLE) && locked_next && CPLLLOCK;
            locked        <= locked_next;
        end
    end

    // The mux is only reloaded on the first PD cycle, so it never moves while
    // the CPLL is powered up.
    always_comb begin
        state_next   = state;
        count_next   = count;
        sel_cap_next = sel_cap;
        sel_next     = CPLLREFCLKSEL;
        locked_next  = locked;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                if (sel_req) begin
                    if (sel_new == 3'b000) begin
                        err_next = 1'b1;
                    end else if (sel_new == CPLLREFCLKSEL) begin
                        done_next   = 1'b1;
                        locked_next = 1'b1;
                    end else begin
                        sel_cap_next = sel_new;
                        state_next   = PD;
                        count_next   = '0;
                    end
                end
            end
            PD: begin
                if (count == '0) begin
                    sel_next = sel_cap;
                end
                if (count == PD_LAST) begin
                    state_next = RST;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            RST: begin
                if (count == RST_LAST) begin
                    state_next = LOCK;
                    count_next = CW'(1);
                end else begin
                    count_next = count + 1'b1;
                end
            end
            LOCK: begin
                if (CPLLLOCK) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    done_next   = 1'b1;
                    locked_next = 1'b1;
                end else if (count == LOCK_MAX) begin
                    state_next  = IDLE;
                    count_next  = '0;
                    err_next    = 1'b1;
                    locked_next = 1'b0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gtxe2_chnl_cpll_refsel_ctrl.sv
// Directed bench for the CPLL reference-select sequencer: power-up, switching,
// rejected/no-op requests, lock timeout and reset abort.
module tb_gtxe2_chnl_cpll_refsel_ctrl;

    logic       clk;
    logic       rst;
    logic       sel_req;
    logic [2:0] sel_new;
    logic       CPLLLOCK;
    logic [2:0] CPLLREFCLKSEL;
    logic       CPLLPD;
    logic       CPLLRESET;
    logic       sel_busy;
    logic       sel_done;
    logic       sel_err;
    logic       cpll_ready;

    int vectors;
    int miscompares;

    gtxe2_chnl_cpll_refsel_ctrl #(
        .INIT_SEL    (3'b001),
        .PD_CYCLES   (16),
        .RST_CYCLES  (8),
        .LOCK_TIMEOUT(4096)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel_req      (sel_req),
        .sel_new      (sel_new),
        .CPLLLOCK     (CPLLLOCK),
        .CPLLREFCLKSEL(CPLLREFCLKSEL),
        .CPLLPD       (CPLLPD),
        .CPLLRESET    (CPLLRESET),
        .sel_busy     (sel_busy),
        .sel_done     (sel_done),
        .sel_err      (sel_err),
        .cpll_ready   (cpll_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Follows one sequence from the current cycle until sel_busy drops,
    // raising CPLLLOCK once lock_delay LOCK cycles have been observed.
    task automatic monitor_sequence(input int lock_delay, input int bound,
                                    output int pd_cnt, output int rst_cnt,
                                    output int lock_cnt, output int done_cnt,
                                    output int err_cnt, output int glitch);
        logic [2:0] prev_sel;
        bit finished;
        pd_cnt = 0; rst_cnt = 0; lock_cnt = 0; done_cnt = 0; err_cnt = 0; glitch = 0;
        finished = 0;
        prev_sel = CPLLREFCLKSEL;
        for (int i = 0; i < bound; i++) begin
            if (CPLLREFCLKSEL !== prev_sel && CPLLPD !== 1'b1) glitch++;
            prev_sel = CPLLREFCLKSEL;
            if (CPLLPD) pd_cnt++;
            if (CPLLRESET) rst_cnt++;
            if (sel_busy && !CPLLPD && !CPLLRESET) begin
                lock_cnt++;
                if (lock_cnt == lock_delay) CPLLLOCK = 1'b1;
            end
            if (sel_done) done_cnt++;
            if (sel_err) err_cnt++;
            if (!sel_busy) begin
                finished = 1;
                break;
            end
            tick();
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("[TB] FAIL seq_timeout: got busy after %0d cycles expected idle", bound);
        end
    endtask

    task automatic test_reset();
        int pd_c, rst_c, lock_c, done_c, err_c, gl;
        rst = 1'b1; sel_req = 1'b0; sel_new = 3'b000; CPLLLOCK = 1'b0;
        repeat (3) tick();
        expect_val("rst_pd", CPLLPD, 1);
        expect_val("rst_reset", CPLLRESET, 0);
        expect_val("rst_sel", CPLLREFCLKSEL, 1);
        expect_val("rst_busy", sel_busy, 1);
        expect_val("rst_done_err", {sel_done, sel_err}, 0);
        expect_val("rst_ready", cpll_ready, 0);
        rst = 1'b0;
        monitor_sequence(5, 200, pd_c, rst_c, lock_c, done_c, err_c, gl);
        expect_val("pwrup_pd_cycles", pd_c, 16);
        expect_val("pwrup_rst_cycles", rst_c, 8);
        expect_val("pwrup_lock_cycles", lock_c, 5);
        expect_val("pwrup_done", done_c, 1);
        expect_val("pwrup_err", err_c, 0);
        expect_val("pwrup_ready", cpll_ready, 1);
        expect_val("pwrup_sel", CPLLREFCLKSEL, 1);
        tick();
        expect_val("pwrup_done_one_cycle", sel_done, 0);
        expect_val("pwrup_ready_hold", cpll_ready, 1);
    endtask

    task automatic test_switch();
        int pd_c, rst_c, lock_c, done_c, err_c, gl;
        sel_req = 1'b1; sel_new = 3'b011; CPLLLOCK = 1'b0;
        tick();
        sel_req = 1'b0;
        expect_val("sw_pd_n1", CPLLPD, 1);
        expect_val("sw_busy_n1", sel_busy, 1);
        expect_val("sw_sel_n1_old", CPLLREFCLKSEL, 1);
        tick();
        expect_val("sw_sel_n2", CPLLREFCLKSEL, 3);
        expect_val("sw_pd_n2", CPLLPD, 1);
        monitor_sequence(4, 200, pd_c, rst_c, lock_c, done_c, err_c, gl);
        expect_val("sw_pd_cycles", pd_c + 1, 16);
        expect_val("sw_rst_cycles", rst_c, 8);
        expect_val("sw_done", done_c, 1);
        expect_val("sw_err", err_c, 0);
        expect_val("sw_glitch", gl, 0);
        expect_val("sw_ready", cpll_ready, 1);
    endtask

    task automatic test_reject_noop();
        sel_req = 1'b1; sel_new = 3'b000;
        tick();
        sel_req = 1'b0;
        expect_val("rej_err", sel_err, 1);
        expect_val("rej_done", sel_done, 0);
        expect_val("rej_pd", CPLLPD, 0);
        expect_val("rej_busy", sel_busy, 0);
        expect_val("rej_sel", CPLLREFCLKSEL, 3);
        tick();
        expect_val("rej_err_one_cycle", sel_err, 0);
        expect_val("rej_pd_after", CPLLPD, 0);
        sel_req = 1'b1; sel_new = 3'b011;
        tick();
        sel_req = 1'b0;
        expect_val("noop_done", sel_done, 1);
        expect_val("noop_err", sel_err, 0);
        expect_val("noop_pd", CPLLPD, 0);
        expect_val("noop_busy", sel_busy, 0);
        tick();
        expect_val("noop_done_one_cycle", sel_done, 0);
        expect_val("noop_pd_after", CPLLPD, 0);
        expect_val("noop_reset_after", CPLLRESET, 0);
    endtask

    task automatic test_ignore_during_pd();
        int pd_c, rst_c, lock_c, done_c, err_c, gl;
        sel_req = 1'b1; sel_new = 3'b010; CPLLLOCK = 1'b0;
        tick();
        sel_req = 1'b0;
        repeat (3) tick();
        sel_req = 1'b1; sel_new = 3'b111;
        repeat (2) tick();
        sel_req = 1'b0;
        monitor_sequence(3, 200, pd_c, rst_c, lock_c, done_c, err_c, gl);
        expect_val("ign_done", done_c, 1);
        expect_val("ign_err", err_c, 0);
        expect_val("ign_sel", CPLLREFCLKSEL, 2);
        expect_val("ign_glitch", gl, 0);
        repeat (2) tick();
        expect_val("ign_no_queue_busy", sel_busy, 0);
        expect_val("ign_no_queue_sel", CPLLREFCLKSEL, 2);
    endtask

    task automatic test_timeout();
        int pd_c, rst_c, lock_c, done_c, err_c, gl;
        sel_req = 1'b1; sel_new = 3'b101; CPLLLOCK = 1'b0;
        tick();
        sel_req = 1'b0;
        monitor_sequence(0, 5000, pd_c, rst_c, lock_c, done_c, err_c, gl);
        expect_val("to_pd_cycles", pd_c, 16);
        expect_val("to_lock_cycles", lock_c, 4096);
        expect_val("to_err", err_c, 1);
        expect_val("to_done", done_c, 0);
        expect_val("to_ready", cpll_ready, 0);
        expect_val("to_sel", CPLLREFCLKSEL, 5);
        CPLLLOCK = 1'b1;
        repeat (2) tick();
        expect_val("to_err_one_cycle", sel_err, 0);
        expect_val("to_locked_cleared", cpll_ready, 0);
        expect_val("to_idle", sel_busy, 0);
    endtask

    task automatic test_reset_mid_rst();
        int pd_c, rst_c, lock_c, done_c, err_c, gl;
        int waited;
        sel_req = 1'b1; sel_new = 3'b100; CPLLLOCK = 1'b0;
        tick();
        sel_req = 1'b0;
        waited = 0;
        while (CPLLRESET !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        expect_val("mid_reached_rst", CPLLRESET, 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        expect_val("mid_pd", CPLLPD, 1);
        expect_val("mid_reset", CPLLRESET, 0);
        expect_val("mid_sel", CPLLREFCLKSEL, 1);
        expect_val("mid_busy", sel_busy, 1);
        expect_val("mid_ready", cpll_ready, 0);
        rst = 1'b0;
        monitor_sequence(5, 200, pd_c, rst_c, lock_c, done_c, err_c, gl);
        expect_val("mid_pwrup_pd", pd_c, 16);
        expect_val("mid_pwrup_done", done_c, 1);
        expect_val("mid_pwrup_sel", CPLLREFCLKSEL, 1);
        expect_val("mid_pwrup_ready", cpll_ready, 1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; sel_req = 1'b0; sel_new = 3'b000; CPLLLOCK = 1'b0;
        test_reset();
        test_switch();
        test_reject_noop();
        test_ignore_during_pd();
        test_timeout();
        test_reset_mid_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gtxe2_chnl_cpll_refsel_ctrl.md
GTXE2_CHNL_CPLL_REFSEL_CTRL -- requirements
Module: gtxe2_chnl_cpll_refsel_ctrl

Interface
REQ-001 SHALL have parameter INIT_SEL, default 3'b001, the CPLL reference select applied after reset.
REQ-002 SHALL have parameter PD_CYCLES, default 16, the number of cycles CPLLPD is held high per switch (legal >=2).
REQ-003 SHALL have parameter RST_CYCLES, default 8, the number of cycles CPLLRESET is held high (legal >=1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 4096, the maximum number of cycles to wait for CPLLLOCK (legal >=1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sel_req, input, 1 bit: request to switch the reference clock; sampled only in IDLE.
REQ-008 SHALL have port sel_new, input, 3 bits: the requested select code, sampled with sel_req.
REQ-009 SHALL have port CPLLLOCK, input, 1 bit: CPLL lock indication.
REQ-010 SHALL have port CPLLREFCLKSEL, output, 3 bits: registered select code driving the CPLL reference mux.
REQ-011 SHALL have port CPLLPD, output, 1 bit: registered CPLL power-down.
REQ-012 SHALL have port CPLLRESET, output, 1 bit: registered CPLL reset.
REQ-013 SHALL have port sel_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port sel_done, output, 1 bit: one-cycle pulse when a sequence reaches lock.
REQ-015 SHALL have port sel_err, output, 1 bit: one-cycle pulse on a rejected request or a lock timeout.
REQ-016 SHALL have port cpll_ready, output, 1 bit: high in IDLE when the last sequence locked and CPLLLOCK=1.

Function
REQ-017 SHALL implement the FSM states IDLE, PD, RST and LOCK, with all outputs registered.
REQ-018 SHALL, in IDLE with sel_req=1 and sel_new in 3'b001..3'b111 and different from CPLLREFCLKSEL (accept cycle n), enter PD with CPLLPD=1 and sel_busy=1 from cycle n+1.
REQ-019 SHALL load CPLLREFCLKSEL with the captured sel_new at cycle n+2, while CPLLPD is already high; CPLLREFCLKSEL SHALL never change while CPLLPD=0.
REQ-020 SHALL hold CPLLPD high for exactly PD_CYCLES cycles, then enter RST with CPLLPD=0 and CPLLRESET=1 in the same cycle.
REQ-021 SHALL hold CPLLRESET high for exactly RST_CYCLES cycles, then enter LOCK with CPLLRESET=0.
REQ-022 SHALL, in LOCK, count cycles from 1; if CPLLLOCK=1 is sampled at count <= LOCK_TIMEOUT, the next cycle SHALL be IDLE with sel_done=1 and sel_busy=0.
REQ-023 SHALL, if count reaches LOCK_TIMEOUT without CPLLLOCK, go to IDLE with sel_err=1 pulsed, keep CPLLREFCLKSEL at the new value, and clear the locked flag.
REQ-024 SHALL treat sel_req with sel_new=3'b000 (reserved) as rejected: sel_err pulses on cycle n+1, the state remains IDLE, and no output other than sel_err changes.
REQ-025 SHALL treat sel_req with sel_new equal to the current CPLLREFCLKSEL as a no-op: sel_done pulses on cycle n+1 and no PD/RST sequence runs.
REQ-026 SHALL ignore sel_req outside IDLE, with no queuing and no error.
REQ-027 SHALL set the locked flag on sel_done and clear it on timeout; cpll_ready = IDLE and locked flag and CPLLLOCK.
REQ-028 SHALL keep sel_done and sel_err mutually exclusive; each SHALL be high for exactly one cycle.
REQ-029 SHALL size its counters to hold max(PD_CYCLES, RST_CYCLES, LOCK_TIMEOUT) without wrap-around.

Reset
REQ-030 SHALL, while rst=1, force state PD with count cleared, CPLLREFCLKSEL=INIT_SEL, CPLLPD=1, CPLLRESET=0, sel_busy=1, sel_done=0, sel_err=0, cpll_ready=0 and the locked flag cleared.
REQ-031 SHALL, after rst deasserts, run the PD->RST->LOCK power-up sequence with INIT_SEL, with PD lasting PD_CYCLES cycles counted from the first cycle after reset.
REQ-032 SHALL abort any sequence when rst is asserted in any state and apply REQ-030 on the next edge.

Verification
REQ-033 SHALL cover: reset release, CPLLLOCK high 5 cycles after RST -> CPLLPD high 16 cycles, CPLLRESET high 8 cycles, one sel_done pulse, cpll_ready=1, CPLLREFCLKSEL=3'b001.
REQ-034 SHALL cover: from ready, sel_req with sel_new=3'b011 -> CPLLPD high at n+1, CPLLREFCLKSEL=3'b011 at n+2, full sequence, sel_done pulse.
REQ-035 SHALL cover: sel_new=3'b000 and, separately, sel_new equal to the current select -> sel_err pulse at n+1 and sel_done pulse at n+1 respectively, CPLLPD stays 0 in both.
REQ-036 SHALL cover: CPLLLOCK held 0 with LOCK_TIMEOUT=4096 -> sel_err pulse after 4096 LOCK cycles, cpll_ready=0, IDLE.
REQ-037 SHALL cover: sel_req during PD ignored, and rst asserted mid-RST -> the next edge shows CPLLPD=1, CPLLRESET=0, CPLLREFCLKSEL=INIT_SEL.
